// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the launcher state encoding and the default data width.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_BUSY = 2'b10,
        WAIT_DONE = 2'b11
    } launch_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Word FIFO feeding the UART TX launcher.
// Wrap-bit pointers give FULL/EMPTY/occupancy; pushes while FULL are dropped and flagged.
module uart_tx_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_cnt,
    output logic                    o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_overflow;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // FULL uses the pre-pop pointers, so a push at FULL is lost even alongside a pop.
    assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_cnt      = r_wr_ptr - r_rd_ptr;
    assign o_rdata    = r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow = r_overflow;
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push & o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Host-side write buffer in front of the UART TX FSM.
// Launches one queued word per frame as P_DATA plus a one-cycle Data_Valid, then follows busy.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned BUSY_TO    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WR_EN,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  FIFO_CNT,
    output logic                    OVERFLOW,
    output logic                    LOST,
    input  logic                    busy,
    output logic [DATA_WIDTH-1:0]   P_DATA,
    output logic                    Data_Valid
);

    localparam int unsigned TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

    launch_state_e         r_state;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_lost;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic                  r_dv;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_launch;

    // Pop happens at launch, so the FIFO slot frees before the frame is sent.
    assign w_launch   = (r_state == IDLE) && !EMPTY && !busy;
    assign LOST       = r_lost;
    assign P_DATA     = r_pdata;
    assign Data_Valid = r_dv;

    uart_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_push     (WR_EN),
        .i_wdata    (WR_DATA),
        .i_pop      (w_launch),
        .o_rdata    (w_rdata),
        .o_full     (FULL),
        .o_empty    (EMPTY),
        .o_cnt      (FIFO_CNT),
        .o_overflow (OVERFLOW)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_to_cnt <= '0;
            r_lost   <= 1'b0;
            r_pdata  <= '0;
            r_dv     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_pdata <= w_rdata;
                        r_dv    <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_dv     <= 1'b0;
                    r_to_cnt <= '0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_to_cnt == TW'(BUSY_TO - 1)) begin
                        // TX never accepted the frame; give up so the queue keeps draining.
                        r_lost  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomised scoreboard bench for uart_tx_buffer with a behavioural TX responder.
// The reference model is a word queue with capacity DEPTH plus sticky flags.
module tb_uart_tx_buffer;

    localparam int DW      = 8;
    localparam int DEPTH   = 8;
    localparam int BUSY_TO = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    localparam int TX_NORMAL = 0;
    localparam int TX_HOLD   = 1;
    localparam int TX_NEVER  = 2;
    localparam int TX_IDLE   = 3;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b1;
    logic          WR_EN   = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          busy    = 1'b0;
    logic          FULL;
    logic          EMPTY;
    logic [CW-1:0] FIFO_CNT;
    logic          OVERFLOW;
    logic          LOST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;

    always #5 CLK = ~CLK;

    uart_tx_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BUSY_TO    (BUSY_TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .FIFO_CNT   (FIFO_CNT),
        .OVERFLOW   (OVERFLOW),
        .LOST       (LOST),
        .busy       (busy),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Stimulus-owned controls
    int            tx_mode      = TX_IDLE;
    int            tx_len       = 12;
    int            exp_dv_cyc   = -1;
    logic [DW-1:0] exp_dv_val   = '0;
    int            exp_cnt3_cyc = -1;
    bit            timeout_flag = 0;
    bit            end_req      = 0;

    // TX responder state
    int tx_rem = 0;

    // Reference model (monitor-owned)
    logic [DW-1:0] m_q [$];
    int            m_cnt    = 0;
    int            m_before = 0;
    bit            m_ovf    = 0;
    bit            m_lost   = 0;
    logic [DW-1:0] m_pdata  = '0;
    logic [DW-1:0] m_exp    = '0;
    int            lost_due = -1;
    bit            p_wr     = 0;
    logic [DW-1:0] p_data   = '0;
    bit            p_busy   = 0;
    bit            p_dv     = 0;
    int            last_busy_cyc = -100;
    bit            last_busy_own = 0;
    bit            done     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural TX FSM: busy rises the cycle after Data_Valid and lasts a frame.
    always @(posedge CLK) begin
        #2;
        if (tx_mode == TX_NORMAL) begin
            if (tx_rem > 0) begin
                busy = 1'b1;
                tx_rem--;
            end else begin
                busy = 1'b0;
            end
            if (Data_Valid) tx_rem = (tx_len == 0) ? int'($urandom_range(1, 15)) : tx_len;
        end else begin
            busy   = (tx_mode == TX_HOLD);
            tx_rem = 0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            m_q.delete();
            m_cnt    = 0;
            m_ovf    = 0;
            m_lost   = 0;
            m_pdata  = '0;
            lost_due = -1;
            check("rst_empty", int'(EMPTY), 1);
            check("rst_full", int'(FULL), 0);
            check("rst_cnt", int'(FIFO_CNT), 0);
            check("rst_ovf", int'(OVERFLOW), 0);
            check("rst_lost", int'(LOST), 0);
            check("rst_dv", int'(Data_Valid), 0);
            check("rst_pdata", int'(P_DATA), 0);
            p_wr   = 0;
            p_dv   = 0;
            p_busy = busy;
        end else begin
            m_before = m_cnt;
            if (p_wr) begin
                if (m_before == DEPTH) m_ovf = 1;
                else begin
                    m_q.push_back(p_data);
                    m_cnt++;
                end
            end
            if (Data_Valid) begin
                check("dv_nonempty", int'(m_before > 0), 1);
                check("dv_busy_low", int'(p_busy), 0);
                check("dv_one_cycle", int'(p_dv), 0);
                if (last_busy_own) check("dv_gap", int'(cyc - last_busy_cyc >= 3), 1);
                if (m_before > 0) begin
                    m_exp = m_q.pop_front();
                    m_cnt--;
                    check("dv_data", int'(P_DATA), int'(m_exp));
                    m_pdata = m_exp;
                end
                if (tx_mode == TX_NEVER) lost_due = cyc + BUSY_TO + 1;
            end else begin
                check("pdata_hold", int'(P_DATA), int'(m_pdata));
            end
            if (cyc == lost_due) m_lost = 1;
            check("cnt", int'(FIFO_CNT), m_cnt);
            check("empty", int'(EMPTY), int'(m_cnt == 0));
            check("full", int'(FULL), int'(m_cnt == DEPTH));
            check("overflow", int'(OVERFLOW), int'(m_ovf));
            check("lost", int'(LOST), int'(m_lost));
            if (cyc == exp_dv_cyc) begin
                check("latency_dv", int'(Data_Valid), 1);
                check("latency_data", int'(P_DATA), int'(exp_dv_val));
            end
            if (cyc == exp_cnt3_cyc) begin
                check("pushpop_cnt", int'(FIFO_CNT), 3);
                check("pushpop_dv", int'(Data_Valid), 1);
            end
            p_wr   = WR_EN;
            p_data = WR_DATA;
            p_dv   = Data_Valid;
            p_busy = busy;
            if (busy) begin
                last_busy_cyc = cyc;
                last_busy_own = (tx_mode == TX_NORMAL);
            end
        end
        if (end_req && !done) begin
            check("drained", m_q.size(), 0);
            check("no_timeout", int'(timeout_flag), 0);
            done = 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        WR_EN   = 1'b1;
        WR_DATA = d;
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic drain();
        int k     = 0;
        int quiet = 0;
        while (k < 3000 && (m_q.size() != 0 || quiet < BUSY_TO + 6)) begin
            if (busy || Data_Valid) quiet = 0;
            else quiet++;
            tick();
            k++;
        end
        if (k >= 3000) timeout_flag = 1;
    endtask

    initial begin
        int k;
        RST = 1'b1;
        repeat (3) tick();
        RST     = 1'b0;
        tx_mode = TX_NORMAL;
        repeat (2) tick();

        // Single word latency
        exp_dv_val = 8'hA5;
        exp_dv_cyc = cyc + 3;
        push(8'hA5);
        drain();

        // Burst in order
        for (int i = 1; i <= 8; i++) push(DW'(i));
        drain();

        // Overflow while TX is held busy
        tx_mode = TX_HOLD;
        repeat (2) tick();
        for (int i = 1; i <= 9; i++) push(DW'(8'h40 + i));
        tick();
        tx_mode = TX_NORMAL;
        drain();

        // Busy never rises: launch abandoned
        tx_mode = TX_NEVER;
        push(8'h3C);
        repeat (BUSY_TO + 8) tick();
        tx_mode = TX_NORMAL;
        push(8'h5A);
        drain();

        // Push and pop on the same edge at occupancy 3
        tx_mode = TX_HOLD;
        tick();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        WR_EN        = 1'b1;
        WR_DATA      = 8'hC4;
        tx_mode      = TX_NORMAL;
        exp_cnt3_cyc = cyc + 2;
        tick();
        WR_EN = 1'b0;
        drain();

        // Reset in the middle of a frame with words queued
        for (int i = 1; i <= 5; i++) push(DW'(8'hD0 + i));
        k = 0;
        while (!busy && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) timeout_flag = 1;
        repeat (2) tick();
        RST     = 1'b1;
        tx_mode = TX_IDLE;
        repeat (2) tick();
        RST = 1'b0;
        repeat (20) tick();
        tx_mode = TX_NORMAL;
        push(8'h77);
        drain();

        // Random traffic with random frame lengths and held-busy intervals
        tx_len = 0;
        for (int i = 0; i < 800; i++) begin
            if (tx_mode == TX_NORMAL && $urandom_range(0, 99) < 3) tx_mode = TX_HOLD;
            else if (tx_mode == TX_HOLD && $urandom_range(0, 99) < 20) tx_mode = TX_NORMAL;
            WR_EN   = ($urandom_range(0, 99) < 35);
            WR_DATA = DW'($urandom);
            tick();
        end
        WR_EN   = 1'b0;
        tx_mode = TX_NORMAL;
        drain();

        end_req = 1;
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
